// File: rtl/cordic_gain_comp.sv
// CORDIC output stage: removes the rotation gain from X/Y, flags residual-angle
// convergence and hands cos/sin out through a two-stage valid/ready pipeline.

module cordic_gain_lane #(
  parameter int W      = 16,
  parameter int KCONST = 39797,
  parameter int ROUND  = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         adv1,
  input  logic         adv2,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);
  localparam int PW = W + 17;
  localparam logic [PW-1:0] KX   = PW'(KCONST);
  localparam logic [PW-1:0] RADD = (ROUND != 0) ? PW'(32768) : '0;

  logic [PW-1:0] din_x, prod_q, rnd;
  logic          unused_lane;

  // Both operands fit in PW bits, so the low PW bits of the product are exact.
  assign din_x       = {{17{din[W-1]}}, din};
  assign rnd         = prod_q + RADD;
  assign unused_lane = ^{rnd[PW-1:W+16], rnd[15:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_q <= '0;
      dout   <= '0;
    end else begin
      if (adv1) prod_q <= din_x * KX;
      if (adv2) dout   <= rnd[W+15:16];
    end
  end
endmodule

module cordic_gain_comp #(
  parameter int W      = 16,
  parameter int KCONST = 39797,
  parameter int ROUND  = 1,
  parameter int ZTOL   = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] Xin,
  input  logic [W-1:0] Yin,
  input  logic [W-1:0] Zin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] cos_out,
  output logic [W-1:0] sin_out,
  output logic [W-1:0] zres_out,
  output logic         conv_out
);
  localparam int NUM_LANES = 2;
  localparam int STAGES    = 2;

  logic [STAGES:1]                vld_pipe;
  logic                           adv1, adv2;
  logic [NUM_LANES-1:0][W-1:0]    lane_d, lane_q;
  logic [W:0]                     z_ext, z_abs;
  logic                           conv_d, conv1_q;
  logic [W-1:0]                   z1_q;

  assign adv2      = ~vld_pipe[2] | out_ready;
  assign adv1      = ~vld_pipe[1] | adv2;
  assign in_ready  = adv1;
  assign out_valid = vld_pipe[2];

  assign lane_d  = {Yin, Xin};
  assign cos_out = lane_q[0];
  assign sin_out = lane_q[1];

  generate
    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
      cordic_gain_lane #(.W(W), .KCONST(KCONST), .ROUND(ROUND)) u_lane (
        .clk  (clk),
        .rst_n(rst_n),
        .adv1 (adv1),
        .adv2 (adv2),
        .din  (lane_d[g]),
        .dout (lane_q[g])
      );
    end
  endgenerate

  // One extra bit so the most negative Z has a representable magnitude.
  assign z_ext  = {Zin[W-1], Zin};
  assign z_abs  = z_ext[W] ? (~z_ext + 1'b1) : z_ext;
  assign conv_d = (z_abs <= (W+1)'(ZTOL));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      z1_q     <= '0;
      conv1_q  <= 1'b0;
      zres_out <= '0;
      conv_out <= 1'b0;
    end else begin
      if (adv1) begin
        vld_pipe[1] <= in_valid;
        z1_q        <= Zin;
        conv1_q     <= conv_d;
      end
      if (adv2) begin
        vld_pipe[2] <= vld_pipe[1];
        zres_out    <= z1_q;
        conv_out    <= conv1_q;
      end
    end
  end
endmodule

// File: tb/tb_cordic_gain_comp.sv
// Randomized and directed bench for cordic_gain_comp against an arithmetic
// reference model with a scoreboard queue.

module tb_cordic_gain_comp;
  logic        clk, rst_n;
  logic        in_valid, in_ready, out_valid, out_ready, conv_out;
  logic [15:0] Xin, Yin, Zin, cos_out, sin_out, zres_out;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [15:0] c, s, z;
    logic        v;
    int          stamp;
  } exp_t;
  exp_t q[$];

  cordic_gain_comp #(.W(16), .KCONST(39797), .ROUND(1), .ZTOL(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .Xin(Xin), .Yin(Yin), .Zin(Zin),
    .out_valid(out_valid), .out_ready(out_ready),
    .cos_out(cos_out), .sin_out(sin_out), .zres_out(zres_out), .conv_out(conv_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // x * 0.607252935 in the same fixed point, rounded half up
  function automatic logic [15:0] mk(input logic [15:0] x);
    longint p;
    p = longint'($signed(x)) * 39797;
    p = (p + 32768) >>> 16;
    return p[15:0];
  endfunction

  function automatic logic mconv(input logic [15:0] z);
    int zi;
    zi = int'($signed(z));
    return (zi <= 4) && (zi >= -4);
  endfunction

  task automatic test_reset();
    #12;
    checks++;
    if (out_valid !== 1'b0 || cos_out !== 16'h0 || sin_out !== 16'h0 ||
        zres_out !== 16'h0 || conv_out !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs: got v=%b c=%h s=%h z=%h cv=%b want all zero",
               out_valid, cos_out, sin_out, zres_out, conv_out);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  // One sample with out_ready=1; checks latency of exactly two cycles
  task automatic test_vector(input string name, input logic [15:0] x, y, z,
                             input logic [15:0] ec, es, input logic ecv);
    @(negedge clk);
    in_valid = 1'b1; Xin = x; Yin = y; Zin = z; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL %s_early: out_valid=%b want 0 after 1 cycle", name, out_valid);
    end
    @(negedge clk); #1;
    checks++;
    if (out_valid !== 1'b1 || cos_out !== ec || sin_out !== es ||
        conv_out !== ecv || zres_out !== z) begin
      failures++;
      $display("FAIL %s: got v=%b c=%h s=%h cv=%b z=%h want v=1 c=%h s=%h cv=%b z=%h",
               name, out_valid, cos_out, sin_out, conv_out, zres_out, ec, es, ecv, z);
    end
  endtask

  task automatic test_directed();
    test_vector("vec1",  16'h4000, 16'h0000, 16'h0000, 16'h26DD, 16'h0000, 1'b1);
    test_vector("vec2",  16'hC000, 16'h7FFF, 16'h0005, 16'hD923, 16'h4DBA, 1'b0);
    test_vector("conv_min", 16'h1234, 16'h0001, 16'h8000, mk(16'h1234), mk(16'h0001), 1'b0);
    test_vector("conv_m4",  16'h0000, 16'h8000, 16'hFFFC, 16'h0000, mk(16'h8000), 1'b1);
    test_vector("conv_m5",  16'h7FFF, 16'hFFFF, 16'hFFFB, mk(16'h7FFF), mk(16'hFFFF), 1'b0);
    test_vector("conv_p4",  16'h0001, 16'h4000, 16'h0004, mk(16'h0001), 16'h26DD, 1'b1);
  endtask

  task automatic test_stall();
    logic [15:0] got[$];
    logic [15:0] want[3];
    want[0] = 16'h09B7; want[1] = 16'h136F; want[2] = 16'h1D26;
    @(negedge clk);
    in_valid = 1'b1; Xin = 16'h1000; Yin = 16'h0; Zin = 16'h0; out_ready = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL stall_accept1: in_ready=%b want 1", in_ready); end
    @(negedge clk); Xin = 16'h2000; #1;
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL stall_accept2: in_ready=%b want 1", in_ready); end
    @(negedge clk); Xin = 16'h3000;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || cos_out !== 16'h09B7) begin
        failures++;
        $display("FAIL stall_hold%0d: in_ready=%b v=%b c=%h want 0 1 09b7", i, in_ready, out_valid, cos_out);
      end
      if (i < 3) @(negedge clk);
    end
    @(negedge clk); out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      if (out_valid && out_ready) got.push_back(cos_out);
      @(negedge clk); in_valid = 1'b0;
    end
    checks++;
    if (got.size() != 3) begin
      failures++;
      $display("FAIL stall_count: got %0d samples want 3", got.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (got[i] !== want[i]) begin
          failures++;
          $display("FAIL stall_order%0d: got %h want %h", i, got[i], want[i]);
        end
      end
    end
  endtask

  // Streams n random samples; rmode 0: out_ready=1, 1: toggling, 2: random.
  // vmode 0: in_valid held high, 1: random gaps.
  task automatic run_stream(input string name, input int n, input int rmode, input int vmode);
    int sent = 0;
    int recv = 0;
    logic pend = 1'b0;
    logic pov = 1'b0, por = 1'b1;
    logic [15:0] pc = '0, ps = '0, pz = '0;
    logic pcv = 1'b0;
    logic [15:0] cx = '0, cy = '0, cz = '0;
    int budget = n * 6 + 40;
    int c;
    q.delete();
    for (c = 0; c < budget; c++) begin
      @(negedge clk);
      if (!pend && sent < n && (vmode == 0 || $urandom_range(0, 1) == 1)) begin
        cx = 16'($urandom); cy = 16'($urandom);
        cz = ($urandom_range(0, 1) == 1) ? 16'($urandom) : 16'($urandom_range(0, 12) - 6);
        pend = 1'b1;
      end
      in_valid = pend; Xin = cx; Yin = cy; Zin = cz;
      out_ready = (rmode == 0) ? 1'b1 : (rmode == 1) ? ((c % 2) == 0) : 1'($urandom_range(0, 1));
      #1;
      if (pov && !por) begin
        checks++;
        if (out_valid !== 1'b1 || cos_out !== pc || sin_out !== ps ||
            zres_out !== pz || conv_out !== pcv) begin
          failures++;
          $display("FAIL %s_hold: c=%0d got v=%b c=%h s=%h want v=1 c=%h s=%h",
                   name, c, out_valid, cos_out, sin_out, pc, ps);
        end
      end
      if (q.size() > 0 && q[0].stamp <= c - 2) begin
        checks++;
        if (out_valid !== 1'b1) begin
          failures++;
          $display("FAIL %s_gap: c=%0d out_valid=%b want 1 with data queued", name, c, out_valid);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (q.size() == 0) begin
          failures++;
          $display("FAIL %s_extra: c=%0d unexpected output c=%h", name, c, cos_out);
        end else begin
          if (cos_out !== q[0].c || sin_out !== q[0].s || zres_out !== q[0].z || conv_out !== q[0].v) begin
            failures++;
            $display("FAIL %s_data: c=%0d got c=%h s=%h z=%h cv=%b want c=%h s=%h z=%h cv=%b",
                     name, c, cos_out, sin_out, zres_out, conv_out, q[0].c, q[0].s, q[0].z, q[0].v);
          end
          void'(q.pop_front());
          recv++;
        end
      end
      if (in_valid && in_ready) begin
        q.push_back('{c: mk(cx), s: mk(cy), z: cz, v: mconv(cz), stamp: c});
        sent++;
        pend = 1'b0;
      end
      pov = out_valid; por = out_ready;
      pc = cos_out; ps = sin_out; pz = zres_out; pcv = conv_out;
      if (sent == n && q.size() == 0) break;
    end
    in_valid = 1'b0;
    checks++;
    if (sent != n || recv != n || q.size() != 0) begin
      failures++;
      $display("FAIL %s_complete: sent=%0d recv=%0d left=%0d want %0d/%0d/0", name, sent, recv, q.size(), n, n);
    end
  endtask

  task automatic test_reset_mid_stall();
    @(negedge clk);
    in_valid = 1'b1; Xin = 16'h1000; Yin = 16'h2000; Zin = 16'h0001; out_ready = 1'b0;
    @(negedge clk); Xin = 16'h2000;
    @(negedge clk); in_valid = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL rst_fill: v=%b in_ready=%b want 1 0", out_valid, in_ready);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || cos_out !== 16'h0 || sin_out !== 16'h0 ||
        zres_out !== 16'h0 || conv_out !== 1'b0) begin
      failures++;
      $display("FAIL rst_async: v=%b c=%h s=%h z=%h cv=%b want all zero",
               out_valid, cos_out, sin_out, zres_out, conv_out);
    end
    #1 rst_n = 1'b1;
    @(negedge clk);
    in_valid = 1'b1; Xin = 16'h3000; Yin = 16'h0; Zin = 16'h0; out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL rst_release: in_ready=%b v=%b want 1 0", in_ready, out_valid);
    end
    @(negedge clk); in_valid = 1'b0; #1;
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL rst_stale: v=%b want 0 (no queued sample survives)", out_valid);
    end
    @(negedge clk); #1;
    checks++;
    if (out_valid !== 1'b1 || cos_out !== 16'h1D26) begin
      failures++;
      $display("FAIL rst_first: v=%b c=%h want 1 1d26", out_valid, cos_out);
    end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    Xin = '0; Yin = '0; Zin = '0;
    test_reset();
    test_directed();
    test_stall();
    run_stream("full_rate", 40, 0, 0);
    run_stream("toggle", 40, 1, 0);
    run_stream("random", 120, 2, 1);
    test_reset_mid_stall();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
